// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a registered one-hot grant,
// per-owner hold limit and a rotating priority pointer.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       busy,
    output logic       preempt
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    grant_q, grant_d;
    logic [2:0]    grant_id_q, grant_id_d;
    logic          preempt_q, preempt_d;

    logic [7:0]    ereq;
    logic          found;
    logic [2:0]    win;
    logic [2:0]    idx;

    assign ereq = req & mask;

    // Search starts at ptr and wraps, so ptr is highest priority.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && ereq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BUSY;
                    grant_d    = 8'b1 << win;
                    grant_id_d = win;
                    cnt_d      = CW'(1);
                end else begin
                    grant_d = 8'h00;
                end
            end
            BUSY: begin
                // Release wins over timeout when both happen on the same edge.
                if (!ereq[grant_id_q]) begin
                    state_d = IDLE;
                    grant_d = 8'h00;
                    ptr_d   = grant_id_q + 3'd1;
                end else if (cnt_q == CW'(MAX_HOLD)) begin
                    state_d   = IDLE;
                    grant_d   = 8'h00;
                    ptr_d     = grant_id_q + 3'd1;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            cnt_q      <= '0;
            grant_q    <= 8'h00;
            grant_id_q <= 3'd0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = |grant_q;
    assign preempt  = preempt_q;

endmodule
